// File: rtl/sabr_fx_pkg.sv
// Shared fixed-point definitions for the SABR multiply/normalize/SDE-update path.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sabr_fx_pkg;

    // Default datapath geometry: 78s x 54s multiplier, Q.52 fixed point.
    localparam int PROD_W     = 131;
    localparam int OUT_W      = 78;
    localparam int FRAC_SHIFT = 52;
    localparam int CNT_W      = 32;

    // Width after rounding and shifting, including the carry-absorbing extra bit.
    localparam int SHIFT_W    = PROD_W + 1 - FRAC_SHIFT;

    typedef logic signed [PROD_W-1:0]  prod_t;
    typedef logic signed [OUT_W-1:0]   fx_t;
    typedef logic signed [SHIFT_W-1:0] shifted_t;

    localparam fx_t OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam fx_t OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

endpackage

// File: rtl/sabr_fx_round_sat.sv
// Combinational round-half-up / arithmetic shift / saturate for signed fixed point.
// Latency: 0 cycles (pure combinational, round and clamp halves are independent).
// Backpressure: none; the caller owns all handshaking.
//
// Ports:
//   prod   -> rnd : (sext(prod) + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, SH_W bits
//   rnd_in -> res, sat : clamp of a rounded value into OUT_W signed bits
// The two halves are exposed separately so a caller can place a register between them.
module sabr_fx_round_sat
    import sabr_fx_pkg::*;
#(
    parameter int PROD_W     = sabr_fx_pkg::PROD_W,
    parameter int OUT_W      = sabr_fx_pkg::OUT_W,
    parameter int FRAC_SHIFT = sabr_fx_pkg::FRAC_SHIFT,
    localparam int SH_W      = PROD_W + 1 - FRAC_SHIFT
) (
    input  logic [PROD_W-1:0] prod,
    output logic [SH_W-1:0]   rnd,
    input  logic [SH_W-1:0]   rnd_in,
    output logic [OUT_W-1:0]  res,
    output logic              sat
);

    localparam logic [PROD_W:0] HALF = (PROD_W+1)'(1) << (FRAC_SHIFT - 1);

    // One extra sign bit so the +HALF carry out of the most positive product
    // stays positive instead of wrapping.
    logic [PROD_W:0] biased;
    assign biased = {prod[PROD_W-1], prod} + HALF;

    // Taking the upper bits of the biased sum is the arithmetic right shift.
    assign rnd = biased[PROD_W:FRAC_SHIFT];

    // Fraction bits only matter through the carry into the kept bits.
    logic unused_frac;
    assign unused_frac = ^biased[FRAC_SHIFT-1:0];

    generate
        if (SH_W > OUT_W) begin : g_clamp
            // In range iff every bit from the output sign bit upward agrees.
            logic [SH_W-OUT_W:0] hi_bits;
            logic                ovf;
            assign hi_bits = rnd_in[SH_W-1:OUT_W-1];
            assign ovf     = !((&hi_bits) || !(|hi_bits));

            always_comb begin
                res = rnd_in[OUT_W-1:0];
                sat = 1'b0;
                if (ovf) begin
                    sat = 1'b1;
                    res = rnd_in[SH_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                         : {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
        end else begin : g_extend
            // Rounded value always fits; just sign-extend.
            assign res = OUT_W'($signed(rnd_in));
            assign sat = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/sabr_fx_mul_normalize.sv
// Normalizes the raw 131-bit signed product to 78-bit fixed point with rounding and saturation.
// Latency: 2 cycles from accept to res_out; 1 sample/cycle throughput.
// Backpressure: valid/ready; out_ready stalls both stages, in_ready = !s1_valid | !out_valid | out_ready.
//
// Ports:
//   ap_clk, ap_rst          : clock, synchronous active-high reset
//   prod_in/in_valid/in_ready : product input handshake
//   res_out/res_sat/out_valid/out_ready : normalized result handshake (res_sat = clamped)
//   clear_sat               : pulse clearing sat_count and sat_sticky
//   sat_count, sat_sticky   : saturated-result statistics, counted on delivery
module sabr_fx_mul_normalize
    import sabr_fx_pkg::*;
#(
    parameter int PROD_W     = sabr_fx_pkg::PROD_W,
    parameter int OUT_W      = sabr_fx_pkg::OUT_W,
    parameter int FRAC_SHIFT = sabr_fx_pkg::FRAC_SHIFT,
    parameter int CNT_W      = sabr_fx_pkg::CNT_W
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  res_out,
    output logic              res_sat,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              clear_sat,
    output logic [CNT_W-1:0]  sat_count,
    output logic              sat_sticky
);

    localparam int SH_W = PROD_W + 1 - FRAC_SHIFT;

    logic              s1_valid;
    logic [SH_W-1:0]   s1_rnd;
    logic [SH_W-1:0]   rnd_c;
    logic [OUT_W-1:0]  res_c;
    logic              sat_c;
    logic              en1;
    logic              en2;
    logic              sat_event;

    sabr_fx_round_sat #(
        .PROD_W     (PROD_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_round_sat (
        .prod   (prod_in),
        .rnd    (rnd_c),
        .rnd_in (s1_rnd),
        .res    (res_c),
        .sat    (sat_c)
    );

    // Each stage advances when its downstream slot is empty or being drained.
    assign en2      = !out_valid || out_ready;
    assign en1      = !s1_valid || en2;
    assign in_ready = en1;

    // Statistics track what the consumer actually took, not what was computed.
    assign sat_event = out_valid && out_ready && res_sat;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_valid  <= 1'b0;
            s1_rnd    <= '0;
            out_valid <= 1'b0;
            res_out   <= '0;
            res_sat   <= 1'b0;
        end else begin
            if (en1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_rnd <= rnd_c;
                end
            end
            if (en2) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    res_out <= res_c;
                    res_sat <= sat_c;
                end
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            sat_count  <= '0;
            sat_sticky <= 1'b0;
        end else if (sat_event) begin
            // A delivered event in the clear cycle is kept as the first new event.
            sat_sticky <= 1'b1;
            if (clear_sat) begin
                sat_count <= CNT_W'(1);
            end else if (sat_count != '1) begin
                sat_count <= sat_count + CNT_W'(1);
            end
        end else if (clear_sat) begin
            sat_count  <= '0;
            sat_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sabr_fx_mul_normalize.sv
module tb_sabr_fx_mul_normalize;

    logic         ap_clk = 1'b0;
    logic         ap_rst;
    logic [130:0] prod_in;
    logic         in_valid;
    logic         in_ready;
    logic [77:0]  res_out;
    logic         res_sat;
    logic         out_valid;
    logic         out_ready;
    logic         clear_sat;
    logic [31:0]  sat_count;
    logic         sat_sticky;

    int checks = 0;
    int errors = 0;

    // Expected results in delivery order: {sat, value}
    logic [78:0] expq[$];
    logic [31:0] cnt_m;
    logic        sticky_m;
    logic        last_acc;
    logic        last_dlv;

    always #5 ap_clk = ~ap_clk;

    sabr_fx_mul_normalize dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .prod_in    (prod_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .res_out    (res_out),
        .res_sat    (res_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clear_sat  (clear_sat),
        .sat_count  (sat_count),
        .sat_sticky (sat_sticky)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: floor((p + 2^51) / 2^52), then clamp to the signed 78-bit range.
    function automatic logic [78:0] model(input logic signed [130:0] p);
        logic signed [159:0] v, q, den, mx, mn, rem;
        den = 160'sd1 <<< 52;
        v   = p;
        v   = v + (den / 2);
        q   = v / den;
        rem = v % den;
        if (v < 0 && rem != 0) q = q - 1;
        mx = (160'sd1 <<< 77) - 1;
        mn = -(160'sd1 <<< 77);
        if (q > mx) return {1'b1, mx[77:0]};
        if (q < mn) return {1'b1, mn[77:0]};
        return {1'b0, q[77:0]};
    endfunction

    // Advance one clock: score transfers at this edge, then check statistics.
    task automatic tick();
        logic [78:0] e;
        logic        ev;
        #1;
        last_acc = 1'b0;
        last_dlv = 1'b0;
        ev       = 1'b0;
        if (!ap_rst) begin
            if (in_valid && in_ready) begin
                expq.push_back(model(prod_in));
                last_acc = 1'b1;
            end
            if (out_valid && out_ready) begin
                last_dlv = 1'b1;
                checks++;
                assert (expq.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious_output: observed res_out %0h with no expected sample", res_out);
                end
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    check("res_out", res_out, e[77:0]);
                    check("res_sat", res_sat, e[78]);
                    ev = e[78];
                end
            end
            if (ev) begin
                sticky_m = 1'b1;
                if (clear_sat) cnt_m = 32'd1;
                else if (cnt_m != 32'hffff_ffff) cnt_m = cnt_m + 1;
            end else if (clear_sat) begin
                cnt_m    = '0;
                sticky_m = 1'b0;
            end
        end
        @(posedge ap_clk);
        if (ap_rst) begin
            expq.delete();
            cnt_m    = '0;
            sticky_m = 1'b0;
        end
        #1;
        check("sat_count", sat_count, cnt_m);
        check("sat_sticky", sat_sticky, sticky_m);
    endtask

    function automatic logic [130:0] fx(input int n);
        logic signed [130:0] v;
        v = n;
        return v <<< 52;
    endfunction

    initial begin
        logic [130:0] pmax, pmin, p129;
        logic [159:0] rw;
        logic signed [130:0] rp;
        int nxt, got;

        pmax = {1'b0, {130{1'b1}}};
        pmin = {1'b1, {130{1'b0}}};
        p129 = 131'd1 << 129;
        cnt_m = '0; sticky_m = 1'b0;
        ap_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear_sat = 1'b0; prod_in = '0;

        // Reset state
        tick(); tick();
        ap_rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_res_out", res_out, 0);
        check("rst_res_sat", res_sat, 0);
        check("rst_in_ready", in_ready, 1);

        // Exact and tie rounding, back-to-back, 2-cycle latency
        in_valid = 1'b1; prod_in = fx(3);
        tick();
        check("lat_n1_valid", out_valid, 0);
        prod_in = 131'd1 << 51;
        tick();
        check("lat_n2_valid", out_valid, 1);
        check("lat_n2_res", res_out, 78'd3);
        prod_in = -(131'sd1 <<< 51);
        tick();
        prod_in = -(131'sd3 <<< 51);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();

        // Saturation both directions, then the carry extreme
        in_valid = 1'b1; prod_in = p129;
        tick();
        prod_in = pmin;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("sat_cnt_two", sat_count, 2);
        check("sat_sticky_set", sat_sticky, 1);
        in_valid = 1'b1; prod_in = pmax;
        tick();
        in_valid = 1'b0;
        tick();
        check("carry_valid", out_valid, 1);
        check("carry_res", res_out, {1'b0, {77{1'b1}}});
        check("carry_sat", res_sat, 1);
        repeat (2) tick();

        // Backpressure: only two samples fit while the output is stalled
        out_ready = 1'b0; in_valid = 1'b1; nxt = 1; prod_in = fx(nxt);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (last_acc) begin nxt++; prod_in = fx(nxt); end
            if (c >= 1) begin
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_res", res_out, 78'd1);
            end
        end
        check("bp_accepted", nxt - 1, 2);
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1; got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            check("bp_no_gap", out_valid, 1);
            tick();
            if (last_dlv) got++;
            if (last_acc) begin
                nxt++;
                if (nxt > 5) in_valid = 1'b0;
                else prod_in = fx(nxt);
            end
        end
        check("bp_drained", got, 5);
        in_valid = 1'b0;
        repeat (2) tick();

        // Randomized traffic with random backpressure and clears
        for (int c = 0; c < 400; c++) begin
            rw = {$urandom, $urandom, $urandom, $urandom, $urandom};
            rp = rw[130:0];
            rp = rp >>> $urandom_range(0, 60);
            prod_in   = rp;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clear_sat = ($urandom_range(0, 15) == 0);
            tick();
        end
        in_valid = 1'b0; clear_sat = 1'b0; out_ready = 1'b1;
        repeat (4) tick();

        // Clear collision with a delivered saturated result
        clear_sat = 1'b1;
        tick();
        clear_sat = 1'b0;
        check("clr_alone_cnt", sat_count, 0);
        in_valid = 1'b1; prod_in = p129;
        repeat (7) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("clr_pre_cnt", sat_count, 7);
        out_ready = 1'b0; in_valid = 1'b1; prod_in = pmin;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        check("clr_held_sat", res_sat, 1);
        out_ready = 1'b1; clear_sat = 1'b1;
        tick();
        check("clr_coll_cnt", sat_count, 1);
        check("clr_coll_sticky", sat_sticky, 1);
        tick();
        clear_sat = 1'b0;
        check("clr_next_cnt", sat_count, 0);
        check("clr_next_sticky", sat_sticky, 0);

        // Reset with two samples in flight
        in_valid = 1'b1; prod_in = p129;
        tick();
        prod_in = fx(5);
        tick();
        in_valid = 1'b0; ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_cnt", sat_count, 0);
        in_valid = 1'b1; prod_in = fx(9);
        tick();
        in_valid = 1'b0;
        check("post_rst_n1", out_valid, 0);
        tick();
        check("post_rst_n2_valid", out_valid, 1);
        check("post_rst_n2_res", res_out, 78'd9);
        tick();
        check("post_rst_alone", out_valid, 0);
        repeat (2) tick();
        check("queue_empty", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sabr_fx_mul_normalize.md
Name: sabr_fx_mul_normalize

Overview:
Downstream stage of the SABR datapath's 78s x 54s -> 131-bit signed multiplier. It turns the raw full-width product back into the 78-bit signed fixed-point format used by the SDE update path. It applies round-half-up, an arithmetic right shift and saturation behind a valid/ready handshake. It also keeps a saturation event counter and a sticky flag for Monte Carlo path diagnostics.

Parameters:
PROD_W, 131, width of signed product input (din0_WIDTH + din1_WIDTH - 1)
OUT_W, 78, width of signed normalized output
FRAC_SHIFT, 52, fractional bits removed (right shift amount); 1 <= FRAC_SHIFT < PROD_W - 1
CNT_W, 32, width of saturation event counter

Ports:
ap_clk  in  1  clock; all state updates on rising edge
ap_rst  in  1  synchronous, active-high reset
prod_in  in  PROD_W  signed product from multiplier
in_valid  in  1  prod_in valid
in_ready  out  1  block can accept prod_in this cycle
res_out  out  OUT_W  signed normalized result
res_sat  out  1  res_out was clamped (qualified by out_valid)
out_valid  out  1  res_out/res_sat valid
out_ready  in  1  consumer accepts this cycle
clear_sat  in  1  one-cycle pulse: clear sat_count and sat_sticky
sat_count  out  CNT_W  number of saturated results delivered; sticks at all-ones
sat_sticky  out  1  set on any saturated result delivered; held until clear_sat

Behaviour:
- Reset (ap_rst=1 at clock edge): s1_valid, out_valid, res_out, res_sat, sat_count and sat_sticky all go to 0. Reset mid-operation drops every in-flight sample, with no partial output. in_ready is 1 in the first cycle after reset.
- Pipeline: 2 register stages. With out_ready held high, an input accepted at edge N appears on res_out after edge N+2. Throughput is 1 sample/cycle.
- Stage 1 (round/shift): r = (sext(prod_in, PROD_W+1) + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT.
  - The extra bit absorbs the carry at prod_in = 2^(PROD_W-1)-1.
  - Round-half-up means ties go toward +inf: -0.5 -> 0, +0.5 -> 1.
- Stage 2 (saturate): OUT_MAX = 2^(OUT_W-1)-1 and OUT_MIN = -2^(OUT_W-1).
  - r > OUT_MAX -> res_out = OUT_MAX, res_sat = 1.
  - r < OUT_MIN -> res_out = OUT_MIN, res_sat = 1.
  - Otherwise res_out = r[OUT_W-1:0], res_sat = 0.
- Handshake: en2 = !out_valid | out_ready; en1 = !s1_valid | en2; in_ready = en1.
  - The ready path is combinational from out_ready; this is accepted.
  - A transfer occurs when valid & ready are both high.
  - Stage data registers load only when their enable is high. Held data stays stable while out_valid & !out_ready.
  - When en2=1 and s1_valid=0, out_valid goes to 0 (bubble).
  - Sample order is preserved. No sample is lost or duplicated under any out_ready pattern.
- Saturation statistics update on delivery (out_valid & out_ready & res_sat), not at computation.
  - clear_sat alone: sat_count <= 0, sat_sticky <= 0.
  - clear_sat in the same cycle as a delivered saturated result: sat_count <= 1, sat_sticky <= 1. The event wins over the clear.
  - sat_count at all-ones does not wrap.
- in_valid is ignored while in_ready=0. prod_in is X-tolerant when in_valid=0.

Decomposition:
- Package sabr_fx_pkg holds:
  - PROD_W, OUT_W, FRAC_SHIFT and CNT_W defaults
  - OUT_MAX/OUT_MIN constants
  - typedefs prod_t (signed PROD_W), fx_t (signed OUT_W) and shifted_t (signed PROD_W+1-FRAC_SHIFT)
  - These are shared with the multiplier wrapper and the SDE update stage.
- One natural sub-module: sabr_fx_round_sat. It is the pure combinational round/shift/clamp function, reused by the other normalizers in the path. The top module holds the pipeline registers, handshake and counters.

Test Plan (FRAC_SHIFT=52, OUT_W=78):
- Exact and tie rounding: prod_in = 3*2^52, 2^51, -2^51, -3*2^51 back-to-back with out_ready=1 -> res_out 3, 1, 0, -1, all with res_sat=0, each appearing 2 cycles after acceptance.
- Saturation: prod_in = 2^129 -> res_out = 2^77-1, res_sat=1. prod_in = -2^130 -> res_out = -2^77, res_sat=1. Afterwards sat_count=2 and sat_sticky=1.
- Carry extreme: prod_in = 2^130-1 -> res_out = 2^77-1, res_sat=1, with no wrap to negative.
- Backpressure: push inputs 1*2^52..5*2^52 with out_ready=0 for 6 cycles.
  - Required: in_ready drops after 2 accepted; res_out holds 1 stable.
  - Then raise out_ready -> outputs 1,2,3,4,5 in order, no gaps after the first.
- Clear collision: a saturated result is delivered in the same cycle as clear_sat with sat_count=7 -> sat_count=1, sat_sticky=1. clear_sat alone next cycle -> both 0.
- Reset mid-stream: assert ap_rst for 1 cycle with 2 samples in flight -> out_valid=0, sat_count=0 next cycle. A sample sent after reset emerges alone 2 cycles later.
